// File: rtl/reset_conditioner_if.sv
// Reset-request / conditioned-reset bundle between reset sources and the conditioner.
interface reset_conditioner_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] req_in;
  logic [NCH-1:0] rst_out;
  logic           rst_any;
  logic [NCH-1:0] assert_evt;
  logic [NCH-1:0] glitch_evt;

  modport master (output req_in, input rst_out, rst_any, assert_evt, glitch_evt);
  modport slave  (input req_in, output rst_out, rst_any, assert_evt, glitch_evt);
endinterface

// File: rtl/reset_conditioner.sv
// Multi-channel reset conditioner: synchronise, glitch-filter, stretch and register
// each asynchronous reset request; report assertions and rejected glitches.
module reset_conditioner_ch #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYC    = 2,
  parameter int   STRETCH     = 4,
  parameter logic POL         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rst_out,
  output logic assert_evt,
  output logic glitch_evt
);
  localparam int QW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int HW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;

  // State bit 1 doubles as the registered reset output.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] QUAL   = 2'b01;
  localparam logic [1:0] ACTIVE = 2'b10;
  localparam logic [1:0] HOLD   = 2'b11;

  logic [SYNC_STAGES-1:0] sync;
  logic [1:0]             state;
  logic [QW-1:0]          qcnt;
  logic [HW-1:0]          hcnt;
  logic                   a, s;

  assign a       = ~(req ^ POL);
  assign s       = sync[SYNC_STAGES-1];
  assign rst_out = state[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= '0;
      state      <= (STRETCH > 0) ? HOLD : ACTIVE;
      hcnt       <= HW'(STRETCH);
      qcnt       <= '0;
      assert_evt <= 1'b0;
      glitch_evt <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], a};
      assert_evt <= 1'b0;
      glitch_evt <= 1'b0;
      case (state)
        IDLE: if (s) begin
          if (FILT_CYC == 1) begin
            state      <= ACTIVE;
            assert_evt <= 1'b1;
          end else begin
            state <= QUAL;
            qcnt  <= QW'(1);
          end
        end
        QUAL: begin
          if (!s) begin
            state      <= IDLE;
            glitch_evt <= 1'b1;
          end else if (qcnt == QW'(FILT_CYC - 1)) begin
            state      <= ACTIVE;
            assert_evt <= 1'b1;
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        ACTIVE: if (!s) begin
          if (STRETCH == 0) state <= IDLE;
          else begin
            state <= HOLD;
            hcnt  <= HW'(STRETCH);
          end
        end
        default: begin
          // Re-activation from HOLD extends the same reset, so no new event.
          if (s)                     state <= ACTIVE;
          else if (hcnt == HW'(1))   state <= IDLE;
          else                       hcnt  <= hcnt - HW'(1);
        end
      endcase
    end
  end
endmodule

module reset_conditioner #(
  parameter int             NCH         = 4,
  parameter int             SYNC_STAGES = 2,
  parameter int             FILT_CYC    = 2,
  parameter int             STRETCH     = 4,
  parameter logic [NCH-1:0] IN_POL      = {NCH{1'b1}}
) (
  input logic                clk,
  input logic                rst_n,
  reset_conditioner_if.slave bus
);
  logic [NCH-1:0] rst_w, aevt_w, gevt_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    reset_conditioner_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC),
      .STRETCH     (STRETCH),
      .POL         (IN_POL[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus.req_in[i]),
      .rst_out    (rst_w[i]),
      .assert_evt (aevt_w[i]),
      .glitch_evt (gevt_w[i])
    );
  end

  assign bus.rst_out    = rst_w;
  assign bus.rst_any    = |rst_w;
  assign bus.assert_evt = aevt_w;
  assign bus.glitch_evt = gevt_w;
endmodule

// File: tb/tb_reset_conditioner.sv
// Scoreboard bench: stimulus queues expected edge/event records, a negedge monitor matches them.
module tb_reset_conditioner;
  localparam int         NCH = 4;
  localparam logic [3:0] POL = 4'b0111;

  // kind: 0 = rst_out rise, 1 = rst_out fall, 2 = assert_evt, 3 = glitch_evt
  typedef struct {
    int cyc;
    int ch;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  reset_conditioner_if #(.NCH(NCH)) bus ();

  reset_conditioner #(.NCH(NCH), .IN_POL(POL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic void expect_evt(int c, int ch, int kind);
    exp_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    q.push_back(e);
  endfunction

  task automatic set_ch(int ch, bit act);
    logic [3:0] p;
    p = POL;
    bus.req_in[ch] = act ? p[ch] : ~p[ch];
  endtask

  // Monitor
  logic [3:0] prev_rst = 4'hF;
  logic [3:0] exp_lvl  = 4'hF;

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_evt: actual=none required=cyc %0d ch %0d kind %0d",
                 q[0].cyc, q[0].ch, q[0].kind);
        if (q[0].kind == 0) exp_lvl[q[0].ch] = 1'b1;
        if (q[0].kind == 1) exp_lvl[q[0].ch] = 1'b0;
        void'(q.pop_front());
      end
      for (int ch = 0; ch < NCH; ch++) begin
        for (int k = 0; k < 4; k++) begin
          bit obs;
          case (k)
            0:       obs = bus.rst_out[ch] && !prev_rst[ch];
            1:       obs = !bus.rst_out[ch] && prev_rst[ch];
            2:       obs = bus.assert_evt[ch] === 1'b1;
            default: obs = bus.glitch_evt[ch] === 1'b1;
          endcase
          if (obs) begin
            checks++;
            if (q.size() > 0 && q[0].cyc == cyc && q[0].ch == ch && q[0].kind == k) begin
              if (k == 0) exp_lvl[ch] = 1'b1;
              if (k == 1) exp_lvl[ch] = 1'b0;
              void'(q.pop_front());
            end else begin
              errors++;
              $display("FAIL unexpected_evt: actual=cyc %0d ch %0d kind %0d required=%s",
                       cyc, ch, k, (q.size() > 0) ? "next queued record" : "no event");
            end
          end
        end
      end
      checks++;
      if (bus.rst_any !== |exp_lvl) begin
        errors++;
        $display("FAIL rst_any: cyc %0d actual=%b required=%b", cyc, bus.rst_any, |exp_lvl);
      end
      prev_rst = bus.rst_out;
    end
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    bus.req_in = ~POL;

    // Reset release: 5 reset edges, all outputs fall 4 cycles after release.
    @(negedge clk);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    t0 = cyc;
    for (int ch = 0; ch < NCH; ch++) expect_evt(t0 + 4, ch, 1);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Clean 6-cycle pulse on ch0: high 9 cycles.
    t0 = cyc;
    expect_evt(t0 + 4, 0, 0); expect_evt(t0 + 4, 0, 2); expect_evt(t0 + 13, 0, 1);
    set_ch(0, 1'b1);
    repeat (6) @(negedge clk);
    set_ch(0, 1'b0);
    repeat (20) @(negedge clk);

    // Single-cycle glitch on ch1.
    t0 = cyc;
    expect_evt(t0 + 4, 1, 3);
    set_ch(1, 1'b1);
    @(negedge clk);
    set_ch(1, 1'b0);
    repeat (15) @(negedge clk);

    // Retrigger on ch2: 3 on, 2 off, 3 on -> one 11-cycle assertion.
    t0 = cyc;
    expect_evt(t0 + 4, 2, 0); expect_evt(t0 + 4, 2, 2); expect_evt(t0 + 15, 2, 1);
    set_ch(2, 1'b1);
    repeat (3) @(negedge clk);
    set_ch(2, 1'b0);
    repeat (2) @(negedge clk);
    set_ch(2, 1'b1);
    repeat (3) @(negedge clk);
    set_ch(2, 1'b0);
    repeat (20) @(negedge clk);

    // Active-low ch3 driven low for 5 cycles -> high 8 cycles.
    t0 = cyc;
    expect_evt(t0 + 4, 3, 0); expect_evt(t0 + 4, 3, 2); expect_evt(t0 + 12, 3, 1);
    set_ch(3, 1'b1);
    repeat (5) @(negedge clk);
    set_ch(3, 1'b0);
    repeat (20) @(negedge clk);

    // Reset during ch0 HOLD.
    t0 = cyc;
    expect_evt(t0 + 4, 0, 0); expect_evt(t0 + 4, 0, 2);
    for (int ch = 1; ch < NCH; ch++) expect_evt(t0 + 8, ch, 0);
    for (int ch = 0; ch < NCH; ch++) expect_evt(t0 + 12, ch, 1);
    set_ch(0, 1'b1);
    repeat (3) @(negedge clk);
    set_ch(0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_evts: actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_conditioner.md
Name: reset_conditioner

Overview:
- Parametrised, multi-channel successor to the team's reset deglitcher.
- Each of NCH asynchronous reset requests is processed in four stages:
  - synchronised into clk;
  - qualified by a minimum-width glitch filter;
  - stretched by a programmable hold time;
  - presented as a registered, active-high reset output.
- Sits between board/peripheral reset sources and the protocol blocks.
- Also reports per-channel assertion and rejected-glitch events.

Parameters:
- NCH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- FILT_CYC, 2: consecutive active synchronised samples required to assert (≥1).
- STRETCH, 4: extra cycles rst_out stays asserted after the request drops (≥0).
- IN_POL, {NCH{1'b1}}: per-channel input polarity. 1 = req_in active-high; 0 = active-low.

Ports:
- clk, in, 1: single clock; all logic is posedge clk.
- rst_n, in, 1: synchronous, active-low reset.
- req_in, in, NCH: asynchronous reset requests, polarity set per bit by IN_POL.
- rst_out, out, NCH: conditioned active-high resets, registered.
- rst_any, out, 1: OR of rst_out; combinational from registers only.
- assert_evt, out, NCH: 1-cycle pulse on entry to ACTIVE from IDLE/QUAL.
- glitch_evt, out, NCH: 1-cycle pulse when QUAL aborts (pulse shorter than FILT_CYC).

Behaviour:
- Normalisation and synchronisation:
  - a = req_in[i] XNOR IN_POL[i], giving 1 = active.
  - a passes through SYNC_STAGES flops; s = last stage.
  - Synchroniser flops reset to 0, i.e. the inactive level.
- Per-channel FSM (IDLE, QUAL, ACTIVE, HOLD), evaluated on each edge with rst_n=1:
  - qcnt and hcnt are each sized $clog2(max+1).
  - IDLE (rst_out=0):
    - s=1 and FILT_CYC=1 → ACTIVE, pulse assert_evt.
    - s=1 and FILT_CYC>1 → QUAL, qcnt=1.
  - QUAL (rst_out=0):
    - s=0 → IDLE, pulse glitch_evt.
    - s=1 and qcnt+1==FILT_CYC → ACTIVE, pulse assert_evt.
    - otherwise qcnt++.
  - ACTIVE (rst_out=1):
    - s=0 and STRETCH=0 → IDLE.
    - s=0 and STRETCH>0 → HOLD, hcnt=STRETCH.
  - HOLD (rst_out=1):
    - s=1 → ACTIVE (retrigger; no assert_evt).
    - s=0 and hcnt==1 → IDLE.
    - otherwise hcnt--.
- rst_out is registered and equals 1 in ACTIVE/HOLD. assert_evt and glitch_evt are registered alongside the state transition.
- Latency:
  - req asserted → rst_out rises SYNC_STAGES+FILT_CYC edges later.
  - For an isolated clean pulse of W ≥ FILT_CYC cycles, rst_out is high for W−FILT_CYC+1+STRETCH cycles.
  - Pulses with W < FILT_CYC are rejected.
- Reset (rst_n=0 at an edge, including mid-operation):
  - All synchroniser flops are cleared.
  - State becomes HOLD with hcnt=STRETCH when STRETCH>0; otherwise ACTIVE.
  - rst_out = all 1; assert_evt = glitch_evt = 0.
- After reset release:
  - With inputs idle, rst_out stays 1 for max(STRETCH,1) cycles, then 0.
  - No events are generated by the reset itself.
  - An input already active retriggers HOLD→ACTIVE as normal.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Counters never wrap: qcnt ≤ FILT_CYC−1, hcnt ≥ 1.

Test Plan:
- Defaults used throughout unless stated.
- Reset release: rst_n=0 for 5 cycles, req_in idle → rst_out=4'hF during reset and 4 cycles after release, then 4'h0. assert_evt and glitch_evt stay 0.
- Clean pulse: req_in[0]=1 for 6 cycles.
  - rst_out[0] rises 4 edges after first sample, stays high 9 cycles.
  - assert_evt[0] pulses once, coincident with the rise.
  - rst_any mirrors rst_out[0].
- Glitch: req_in[1]=1 for 1 cycle → rst_out[1] stays 0; glitch_evt[1] pulses once, 4 edges after the sample.
- Retrigger: req_in[2] high 3 cycles, low 2 cycles, high 3 cycles → rst_out[2] is one continuous assertion of 3−2+1+2+3+4=11 cycles, with a single assert_evt[2].
- Polarity: IN_POL=4'b0111, req_in[3] idles 1, driven 0 for 5 cycles → rst_out[3] high 8 cycles; no activity while req_in[3] idles at 1.
- Reset mid-HOLD: during ch0 HOLD, rst_n=0 for 1 cycle → rst_out=4'hF next cycle, events 0; after release ch0 deasserts 4 cycles later with no assert_evt.
